// File: rtl/ao_vector_driver.sv
// ao_vector_driver
// Exhaustive stimulus driver and checker for an AND-OR gate y = (a&b)|(c&d).
// A start request applies vectors 0000..1111 to the gate inputs in order.
// Each vector is held for SETTLE cycles plus one check cycle. The gate output
// is sampled on the edge that leaves the check cycle and compared against the
// expected AND-OR value.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   run request, honoured only while idle
//   y          in   gate output under test
//   a,b,c,d    out  registered gate drive, {a,b,c,d} = current vector
//   busy       out  high while vectors are being applied
//   done       out  one-cycle pulse at the end of a run
//   err_cnt    out  number of mismatching vectors in the last run (0..16)
//   fail_valid out  at least one mismatch seen in the last run
//   fail_vec   out  {a,b,c,d} of the first mismatch
//
// SETTLE must be 1 or larger.
module ao_vector_driver #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       busy,
  output logic       done,
  output logic [4:0] err_cnt,
  output logic       fail_valid,
  output logic [3:0] fail_vec
);

  localparam int unsigned VEC_W  = 4;
  localparam int unsigned ERR_W  = 5;
  localparam int unsigned WCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(SETTLE - 1);
  localparam logic [VEC_W-1:0]  VEC_LAST  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_e;

  state_e state, state_n;

  // Current vector; it is also the registered gate drive.
  logic [VEC_W-1:0]  vec, vec_n;
  logic [WCNT_W-1:0] wcnt, wcnt_n;
  logic              busy_n, done_n;
  logic [ERR_W-1:0]  err_cnt_n;
  logic              fail_valid_n;
  logic [VEC_W-1:0]  fail_vec_n;
  logic              exp_y;
  logic              mismatch;

  assign {a, b, c, d} = vec;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec        <= '0;
      wcnt       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else begin
      vec        <= vec_n;
      wcnt       <= wcnt_n;
      busy       <= busy_n;
      done       <= done_n;
      err_cnt    <= err_cnt_n;
      fail_valid <= fail_valid_n;
      fail_vec   <= fail_vec_n;
    end
  end

  // Next-state, vector sequencing and result accumulation.
  always_comb begin
    state_n      = state;
    vec_n        = vec;
    wcnt_n       = wcnt;
    err_cnt_n    = err_cnt;
    fail_valid_n = fail_valid;
    fail_vec_n   = fail_vec;
    exp_y        = (vec[3] & vec[2]) | (vec[1] & vec[0]);
    mismatch     = 1'b0;

    unique case (state)
      S_IDLE: begin
        // Accepting a run clears the previous results and restarts at 0000.
        if (start) begin
          state_n      = S_WAIT;
          vec_n        = '0;
          wcnt_n       = '0;
          err_cnt_n    = '0;
          fail_valid_n = 1'b0;
          fail_vec_n   = '0;
        end
      end

      S_WAIT: begin
        if (wcnt == WCNT_LAST) begin
          state_n = S_CHECK;
        end else begin
          wcnt_n = wcnt + 1'b1;
        end
      end

      S_CHECK: begin
        mismatch = (y != exp_y);
        if (mismatch) begin
          // Sixteen errors fit in ERR_W bits, so no saturation is needed.
          err_cnt_n = err_cnt + 1'b1;
          if (!fail_valid) begin
            fail_valid_n = 1'b1;
            fail_vec_n   = vec;
          end
        end
        if (vec == VEC_LAST) begin
          state_n = S_DONE;
        end else begin
          state_n = S_WAIT;
          vec_n   = vec + 1'b1;
          wcnt_n  = '0;
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Status flags are registered from the state being entered.
    busy_n = (state_n == S_WAIT) || (state_n == S_CHECK);
    done_n = (state_n == S_DONE);
  end

endmodule

// File: tb/tb_ao_vector_driver.sv
// tb_ao_vector_driver
// Two driver instances (SETTLE=2 and SETTLE=1) each exercise a modelled gate
// whose behaviour is selectable: correct, stuck-at-0/1, inverted, and one- or
// two-cycle registered output. Expected run results are predicted from the
// vector timing and pushed to a per-instance queue; a monitor process checks
// the drive sequence every busy cycle and the results on each done pulse.
`timescale 1ns/1ps
module tb_ao_vector_driver;

  localparam int unsigned SET0 = 2;
  localparam int unsigned SET1 = 1;

  typedef enum int {G_OK, G_ST0, G_ST1, G_INV, G_REG1, G_REG2} gmode_e;

  typedef struct packed {
    int err;
    int fvalid;
    int fvec;
    int len;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] start;
  logic [1:0] y, a, b, c, d, busy, done, fail_valid;
  logic [4:0] err_cnt [2];
  logic [3:0] fail_vec [2];
  logic [1:0] yr1 = '0;
  logic [1:0] yr2 = '0;
  gmode_e     mode [2];

  res_t exp_q0[$];
  res_t exp_q1[$];
  int   run_len [2];
  int   prev_drv [2];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  ao_vector_driver #(.SETTLE(SET0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .y(y[0]),
    .a(a[0]), .b(b[0]), .c(c[0]), .d(d[0]),
    .busy(busy[0]), .done(done[0]), .err_cnt(err_cnt[0]),
    .fail_valid(fail_valid[0]), .fail_vec(fail_vec[0])
  );

  ao_vector_driver #(.SETTLE(SET1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .y(y[1]),
    .a(a[1]), .b(b[1]), .c(c[1]), .d(d[1]),
    .busy(busy[1]), .done(done[1]), .err_cnt(err_cnt[1]),
    .fail_valid(fail_valid[1]), .fail_vec(fail_vec[1])
  );

  function automatic logic ao(input logic [3:0] v);
    return (v[3] & v[2]) | (v[1] & v[0]);
  endfunction

  // Gate response to a vector that has been applied long enough.
  function automatic logic seen(input gmode_e m, input logic [3:0] v);
    case (m)
      G_ST0:   return 1'b0;
      G_ST1:   return 1'b1;
      G_INV:   return ~ao(v);
      default: return ao(v);
    endcase
  endfunction

  function automatic logic gate_y(input gmode_e m, input logic [3:0] v,
                                  input logic r1, input logic r2);
    case (m)
      G_REG1:  return r1;
      G_REG2:  return r2;
      default: return seen(m, v);
    endcase
  endfunction

  always @(posedge clk) begin
    yr1 <= {ao({a[1], b[1], c[1], d[1]}), ao({a[0], b[0], c[0], d[0]})};
    yr2 <= yr1;
  end

  assign y[0] = gate_y(mode[0], {a[0], b[0], c[0], d[0]}, yr1[0], yr2[0]);
  assign y[1] = gate_y(mode[1], {a[1], b[1], c[1], d[1]}, yr1[1], yr2[1]);

  function automatic logic [3:0] drv(input int g);
    return {a[g], b[g], c[g], d[g]};
  endfunction

  // Reference model: vector v is driven for settle+1 cycles and sampled at
  // the end of that window; a gate with delay dly therefore reports the drive
  // present dly cycles earlier, which can be the previous vector (or the
  // drive left over from before the run).
  function automatic res_t predict(input int settle, input gmode_e m, input int prev);
    res_t r;
    int   per;
    int   dly;
    int   t;
    int   dv;
    per      = settle + 1;
    dly      = (m == G_REG1) ? 1 : ((m == G_REG2) ? 2 : 0);
    r.err    = 0;
    r.fvalid = 0;
    r.fvec   = 0;
    r.len    = 16 * per;
    for (int v = 0; v < 16; v++) begin
      t  = (v + 1) * per - 1 - dly;
      dv = (t < 0) ? prev : t / per;
      if (seen(m, 4'(dv)) != ao(4'(v))) begin
        r.err++;
        if (r.fvalid == 0) begin
          r.fvalid = 1;
          r.fvec   = v;
        end
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int g, input gmode_e m);
    res_t e;
    e = predict((g == 0) ? int'(SET0) : int'(SET1), m, prev_drv[g]);
    if (g == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic mon_one(input int g);
    int   per;
    res_t e;
    bit   empty;
    per = (g == 0) ? int'(SET0) + 1 : int'(SET1) + 1;
    if (!rst_n) begin
      run_len[g] = 0;
      return;
    end
    if (busy[g]) begin
      chk($sformatf("drive%0d_len%0d", g, run_len[g]), int'(drv(g)), run_len[g] / per);
      run_len[g]++;
    end
    if (done[g]) begin
      empty = (g == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
      if (empty) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done%0d: done with no run outstanding (cycle %0d)", g, cyc);
      end else begin
        if (g == 0) e = exp_q0.pop_front();
        else        e = exp_q1.pop_front();
        chk($sformatf("err_cnt%0d", g),    int'(err_cnt[g]),    e.err);
        chk($sformatf("fail_valid%0d", g), int'(fail_valid[g]), e.fvalid);
        chk($sformatf("fail_vec%0d", g),   int'(fail_vec[g]),   e.fvec);
        chk($sformatf("run_len%0d", g),    run_len[g],          e.len);
        chk($sformatf("final_drive%0d", g), int'(drv(g)),       15);
      end
      run_len[g] = 0;
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      mon_one(0);
      mon_one(1);
    end
  endtask

  task automatic wait_done(input int g, output int dc);
    dc = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (done[g]) begin
        dc = cyc;
        return;
      end
    end
    n_chk++;
    n_fail++;
    $display("FAIL timeout_done%0d: no done within 400 cycles (cycle %0d)", g, cyc);
  endtask

  // Called at a negedge: request one run and wait for its done pulse.
  task automatic do_run(input int g, input gmode_e m, output int dc);
    mode[g] = m;
    push_exp(g, m);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    wait_done(g, dc);
    prev_drv[g] = 15;
  endtask

  task automatic chk_zero(input int g, input string tag);
    chk($sformatf("%s_busy%0d", tag, g),       int'(busy[g]),       0);
    chk($sformatf("%s_done%0d", tag, g),       int'(done[g]),       0);
    chk($sformatf("%s_drive%0d", tag, g),      int'(drv(g)),        0);
    chk($sformatf("%s_err_cnt%0d", tag, g),    int'(err_cnt[g]),    0);
    chk($sformatf("%s_fail_valid%0d", tag, g), int'(fail_valid[g]), 0);
    chk($sformatf("%s_fail_vec%0d", tag, g),   int'(fail_vec[g]),   0);
  endtask

  initial begin
    int     dc;
    int     g;
    bit     got;
    gmode_e m;

    rst_n       = 1'b1;
    start       = '0;
    mode[0]     = G_OK;
    mode[1]     = G_OK;
    run_len[0]  = 0;
    run_len[1]  = 0;
    prev_drv[0] = 0;
    prev_drv[1] = 0;
    fork
      monitor();
    join_none

    #1 rst_n = 1'b0;
    #2;
    chk_zero(0, "reset");
    chk_zero(1, "reset");
    #9 rst_n = 1'b1;

    // Correct gate, start accepted at edge 10, done after edge 58.
    while (cyc < 9) @(negedge clk);
    do_run(0, G_OK, dc);
    chk("done_cycle", dc, 58);

    repeat (3) @(negedge clk);
    do_run(0, G_ST0, dc);
    repeat (2) @(negedge clk);
    do_run(0, G_ST1, dc);
    repeat (2) @(negedge clk);
    do_run(0, G_INV, dc);

    // Start held high, then toggled randomly, through one whole run.
    repeat (2) @(negedge clk);
    mode[0] = G_ST0;
    push_exp(0, G_ST0);
    start[0] = 1'b1;
    repeat (20) @(negedge clk);
    got = 1'b0;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      if (done[0]) got = 1'b1;
      else start[0] = 1'($urandom_range(0, 1));
    end
    chk("held_start_done", int'(got), 1);
    start[0]    = 1'b0;
    prev_drv[0] = 15;
    // New start in the idle cycle right after the done pulse.
    mode[0] = G_OK;
    push_exp(0, G_OK);
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    chk("restart_busy",       int'(busy[0]),       1);
    chk("restart_err_cnt",    int'(err_cnt[0]),    0);
    chk("restart_fail_valid", int'(fail_valid[0]), 0);
    chk("restart_drive",      int'(drv(0)),        0);
    wait_done(0, dc);

    // SETTLE=1 against registered gates.
    repeat (3) @(negedge clk);
    do_run(1, G_REG1, dc);
    repeat (3) @(negedge clk);
    do_run(1, G_REG2, dc);
    repeat (3) @(negedge clk);
    do_run(1, G_OK, dc);

    // Random gate behaviours on random instances.
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(2, 5)) @(negedge clk);
      g = int'($urandom_range(0, 1));
      m = gmode_e'($urandom_range(0, 5));
      do_run(g, m, dc);
    end

    // Asynchronous reset in the middle of vector 6 of a failing run.
    repeat (3) @(negedge clk);
    mode[0]  = G_ST0;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int n = 0; n < 200 && drv(0) != 4'd6; n++) @(negedge clk);
    chk("reach_vec6", int'(drv(0)), 6);
    chk("mid_run_err_cnt", int'(err_cnt[0]), 1);
    #3 rst_n = 1'b0;
    #1;
    chk_zero(0, "async_reset");
    chk_zero(1, "async_reset");
    @(negedge clk);
    run_len[0] = 0;
    run_len[1] = 0;
    #2 rst_n = 1'b1;
    prev_drv[0] = 0;
    prev_drv[1] = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("post_reset_busy",  int'(busy[0]), 0);
      chk("post_reset_drive", int'(drv(0)),  0);
    end
    do_run(0, G_OK, dc);

    repeat (4) @(negedge clk);
    chk("q0_left", exp_q0.size(), 0);
    chk("q1_left", exp_q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
